uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit serializer, directly downstream of the baud enable generator. Consumes its one-clock `txen` pulse, one pulse per bit period. Accepts a byte over a valid/ready handshake and drives the serial line in 8-N-1 format (or 8-N-2 / 8-E-1 per configuration). The serial line changes only on `txen` boundaries. Every bit is held for exactly one baud period.

Parameters:
- DATA_W, 8, number of data bits per frame, 5..8, sent LSB first.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- txen  input  1  baud enable; one-clk pulse per bit period, from the baud generator.
- tx_valid  input  1  upstream has a byte to send.
- tx_data  input  DATA_W  byte to send; sampled only at handshake.
- tx_ready  output  1  block can accept a byte this cycle.
- txd  output  1  serial line; idle high.
- busy  output  1  frame pending or in progress.
- tx_done  output  1  one-clk pulse when the final stop bit period ends.

Behaviour:
- Reset is asynchronous, active low, on clk and n_rst. Reset values:
  - txd = 1, tx_ready = 1, busy = 0, tx_done = 0.
  - State = IDLE; shift register and counters = 0.
- Handshake:
  - Accept occurs when tx_valid && tx_ready on a rising clk edge.
  - On accept, tx_data is latched into the shift register.
  - tx_ready is 1 only in IDLE and is a registered output. It drops to 0 on the cycle after accept.
  - tx_data may change freely after accept.
- States: IDLE, ARMED, START, DATA, [PARITY], STOP.
  - IDLE: txd=1. Accept -> ARMED.
  - ARMED: txd=1, busy=1. Waits for the next txen; it never drives the start bit mid-period. On txen -> START, txd<=0.
  - START: txd=0. On txen -> DATA, txd<=shreg[0], bit counter = 0.
  - DATA: on each txen, shift right and increment the bit counter. txd follows shreg[0].
    - When the counter reaches DATA_W-1 and txen occurs -> STOP, txd<=1.
    - With the parity feature: -> PARITY instead.
  - STOP: txd=1, held for STOP_BITS txen periods. The txen ending the last stop period -> IDLE.
    - On that same cycle: tx_done=1 for one clk; tx_ready rises next cycle.
- txd is registered. It changes exactly one clk after the txen-sampled edge, and only on cycles following txen.
- Start-to-start latency: (1 + DATA_W + parity + STOP_BITS) txen periods, plus the ARMED wait (0..1 period).
- Back-to-back: upstream may re-assert tx_valid while tx_done pulses. The accept happens the cycle after tx_done and goes through ARMED. Minimum gap is therefore one partial period; txd stays 1 during the gap.
- txen in IDLE: ignored.
- tx_valid in a non-IDLE state: ignored; the data is not captured.
- txen asserted on the same cycle as accept: not consumed by the new frame. ARMED waits for the next txen.
- txen held high continuously (degenerate): the block advances one state per clk. Functionally legal.
- Reset mid-frame: txd returns to 1 immediately (asynchronous). The frame is abandoned; no tx_done.
- Illegal STOP_BITS values: treated as 1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA.
  - txd = even parity, the XOR of all DATA_W latched bits, computed from the byte latched at accept.
  - Frame length grows by one txen period.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan:
- Bench drives txen every 8 clks; send 0x55. Required response:
  - txd sequence per period: 0,1,0,1,0,1,0,1,0,1.
  - tx_done pulses once, 80 clks after the first start-bit edge.
  - tx_ready returns to 1 the next cycle.
- Send 0xA3 with STOP_BITS=2. Required response:
  - txd sequence: 0,1,1,0,0,0,1,0,1,1,1.
  - busy deasserts only after the second stop period.
- Back-to-back 0x00 then 0xFF, with tx_valid held high. Required response:
  - Second byte is accepted the cycle after tx_done.
  - No glitch low on txd between the frames.
  - Frames are 0,0×8,1 then 0,1×8,1.
- Assert tx_valid on the same cycle as txen while IDLE. Required response:
  - txd stays 1 for that whole period.
  - Start bit begins on the following txen.
- Assert n_rst low during the 4th data bit of 0x0F. Required response:
  - txd=1 within the same cycle.
  - tx_ready=1, busy=0.
  - No tx_done.
  - The next byte, 0x81, transmits correctly.
- With UART_TX_PARITY_EN defined, send 0x07 then 0x03. Required response:
  - Parity bit is 1 for 0x07 and 0 for 0x03.
  - Frame length is 11 periods.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit serializer fed by the baud generator's one-clk txen pulse.
//   Takes a DATA_W-bit word over valid/ready and sends it LSB first as
//   start(0), data, [even parity], STOP_BITS x stop(1). All outputs are
//   registered; txd only moves on the clk after a txen-sampled edge.
//
//   Optional feature macro: UART_TX_PARITY_EN (adds an even parity bit
//   between the last data bit and the stop bits).
//
// Ports:
//   clk       system clock
//   n_rst     asynchronous active-low reset
//   txen      baud enable, one clk per bit period
//   tx_valid  upstream has a word to send
//   tx_data   word to send, sampled only at handshake
//   tx_ready  word can be accepted this cycle (registered, IDLE only)
//   txd       serial line, idle high
//   busy      frame pending or in progress
//   tx_done   one-clk pulse when the final stop period ends
module uart_tx_serializer #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              txen,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy,
    output logic              tx_done
);

    // Anything other than 2 stop bits falls back to 1.
    localparam int STOP_N = (STOP_BITS == 2) ? 2 : 1;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd5
`endif
    } state_t;

    state_t             state, state_n;
    logic [DATA_W-1:0]  shreg, shreg_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic               stop_cnt, stop_cnt_n;
    logic               txd_n, ready_n, busy_n, done_n;
    logic               accept;
`ifdef UART_TX_PARITY_EN
    logic               par, par_n;
`endif

    assign accept = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            txd      <= txd_n;
            tx_ready <= ready_n;
            busy     <= busy_n;
            tx_done  <= done_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        txd_n      = txd;
        ready_n    = 1'b0;
        busy_n     = busy;
        done_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n      = par;
`endif
        case (state)
            IDLE: begin
                // txen is ignored here; a txen coinciding with accept is
                // not consumed, ARMED waits for the next one. tx_ready is
                // held low for the tx_done cycle since it is computed from
                // the registered state.
                txd_n   = 1'b1;
                busy_n  = 1'b0;
                ready_n = !accept;
                if (accept) begin
                    state_n = ARMED;
                    shreg_n = tx_data;
                    busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^tx_data;
`endif
                end
            end
            ARMED: begin
                if (txen) begin
                    state_n = START;
                    txd_n   = 1'b0;
                end
            end
            START: begin
                if (txen) begin
                    state_n   = DATA;
                    txd_n     = shreg[0];
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (txen) begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_n    = PARITY;
                        txd_n      = par;
`else
                        state_n    = STOP;
                        txd_n      = 1'b1;
                        stop_cnt_n = 1'b0;
`endif
                    end else begin
                        // shreg[1] is the bit that lands in shreg[0].
                        shreg_n   = shreg >> 1;
                        txd_n     = shreg[1];
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (txen) begin
                    state_n    = STOP;
                    txd_n      = 1'b1;
                    stop_cnt_n = 1'b0;
                end
            end
`endif
            STOP: begin
                if (txen) begin
                    if (stop_cnt == 1'(STOP_N - 1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (1 and 2 stop bits) share
// clk/txen/tx_data; each has its own tx_valid. Stimulus pushes sent bytes
// into per-instance queues; a monitor decodes the serial line one txen
// period at a time and compares each frame against a reference frame built
// from the byte.
`timescale 1ns/1ps
module tb_uart_tx_serializer;
    localparam int DATA_W = 8;
    localparam int DIV    = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        txen = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic [1:0]  tx_valid = 2'b00;
    logic [1:0]  tx_ready, txd, busy, tx_done;

    int errors = 0;
    int checks = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int pushed0 = 0, pushed1 = 0;
    int done0 = 0, done1 = 0;

    uart_tx_serializer #(.DATA_W(DATA_W), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .txen(txen), .tx_valid(tx_valid[0]),
        .tx_data(tx_data), .tx_ready(tx_ready[0]), .txd(txd[0]),
        .busy(busy[0]), .tx_done(tx_done[0])
    );
    uart_tx_serializer #(.DATA_W(DATA_W), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .txen(txen), .tx_valid(tx_valid[1]),
        .tx_data(tx_data), .tx_ready(tx_ready[1]), .txd(txd[1]),
        .busy(busy[1]), .tx_done(tx_done[1])
    );

    always #5 clk = ~clk;

    // Free-running baud enable: one clk high every DIV clks.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt = (cnt + 1) % DIV;
            txen = (cnt == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int flen(input int i);
        return 1 + DATA_W + PAR + (i + 1);
    endfunction

    // Reference frame: bit k is the line level during txen period k.
    function automatic logic [15:0] frame_of(input logic [7:0] b);
        logic [15:0] v;
        int n;
        v = '1;
        v[0] = 1'b0;
        for (int k = 0; k < DATA_W; k++) v[1 + k] = b[k];
        n = 1 + DATA_W;
        if (PAR == 1) v[n] = ^b;
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          in_f[2], pv[2], ptd[2], dexp[2], rexp[2];
        int          nb[2], st_cyc[2];
        logic [15:0] rx[2];
        logic [7:0]  b;
        logic        td;
        bit          ptn;
        int          cyc;
        cyc = 0;
        ptn = 0;
        for (int i = 0; i < 2; i++) begin
            in_f[i] = 0; pv[i] = 0; ptd[i] = 1; dexp[i] = 0; rexp[i] = 0;
            nb[i] = 0; st_cyc[i] = 0; rx[i] = '1;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!n_rst) begin
                    in_f[i] = 0; pv[i] = 0; dexp[i] = 0; rexp[i] = 0;
                end else begin
                    td = txd[i];
                    if (pv[i] && td !== ptd[i])
                        chk("txd_change_after_txen", 32'(ptn), 32'd1);
                    if (rexp[i]) begin
                        chk("ready_after_done", 32'(tx_ready[i]), 32'd1);
                        rexp[i] = 0;
                    end
                    if (dexp[i]) begin
                        chk("done_pulse", 32'(tx_done[i]), 32'd1);
                        chk("busy_clear_on_done", 32'(busy[i]), 32'd0);
                        chk("ready_low_on_done", 32'(tx_ready[i]), 32'd0);
                        chk("start_to_done_clks", 32'(cyc - st_cyc[i]), 32'(flen(i) * DIV));
                        if (tx_done[i] === 1'b1) begin
                            if (i == 0) done0++; else done1++;
                        end
                        dexp[i] = 0;
                        rexp[i] = 1;
                    end else if (tx_done[i] !== 1'b0) begin
                        chk("spurious_done", 32'(tx_done[i]), 32'd0);
                    end
                    if (!in_f[i] && pv[i] && ptd[i] === 1'b1 && td === 1'b0)
                        st_cyc[i] = cyc;
                    if (txen) begin
                        if (in_f[i]) begin
                            chk("busy_in_frame", 32'(busy[i]), 32'd1);
                            rx[i][nb[i]] = td;
                            nb[i]++;
                            if (nb[i] == flen(i)) begin
                                in_f[i] = 0;
                                dexp[i] = 1;
                                if (i == 0) begin
                                    chk("frame_expected_dut0", 32'(q0.size() > 0), 32'd1);
                                    b = (q0.size() > 0) ? q0.pop_front() : 8'h00;
                                end else begin
                                    chk("frame_expected_dut1", 32'(q1.size() > 0), 32'd1);
                                    b = (q1.size() > 0) ? q1.pop_front() : 8'h00;
                                end
                                chk($sformatf("frame_bits_dut%0d_byte%02h", i, b),
                                    32'(rx[i]), 32'(frame_of(b)));
                            end
                        end else if (td === 1'b0) begin
                            chk("busy_in_frame", 32'(busy[i]), 32'd1);
                            in_f[i] = 1;
                            rx[i] = '1;
                            rx[i][0] = 1'b0;
                            nb[i] = 1;
                        end
                    end
                    ptd[i] = td;
                    pv[i] = 1;
                end
            end
            ptn = txen;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input int i, input logic [7:0] b);
        if (i == 0) begin q0.push_back(b); pushed0++; end
        else begin q1.push_back(b); pushed1++; end
    endtask

    task automatic send(input int i, input logic [7:0] b, input bit do_push, input bit hold);
        int n;
        @(negedge clk);
        tx_data = b;
        tx_valid[i] = 1'b1;
        n = 0;
        while (tx_ready[i] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_bound", 32'(n < 2000), 32'd1);
        @(posedge clk);
        if (do_push) push(i, b);
        #1;
        if (!hold) tx_valid[i] = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || tx_ready !== 2'b11) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_within_bound", 32'(n < 3000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  pdone;
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd), 32'h3);
        chk("reset_ready", 32'(tx_ready), 32'h3);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(tx_done), 32'h0);
        #2 n_rst = 1'b1;

        // 8-N-1 0x55 and 8-N-2 0xA3
        send(0, 8'h55, 1, 0);
        drain();
        send(1, 8'hA3, 1, 0);
        drain();

        // Back-to-back with tx_valid held: second accept right after tx_done.
        send(0, 8'h00, 1, 1);
        @(negedge clk);
        tx_data = 8'hFF;
        n = 0;
        pdone = 0;
        while (tx_ready[0] !== 1'b1 && n < 2000) begin
            pdone = tx_done[0];
            @(negedge clk);
            n++;
        end
        chk("b2b_ready_cycle_after_done", 32'(pdone), 32'd1);
        @(posedge clk);
        push(0, 8'hFF);
        #1 tx_valid[0] = 1'b0;
        drain();

        // Accept coinciding with txen: start bit waits a full period.
        n = 0;
        @(negedge clk);
        while (!(txen && tx_ready[0] === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_data = 8'h3C;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        push(0, 8'h3C);
        #1 tx_valid[0] = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || n >= 100) break;
            n++;
        end
        chk("armed_wait_clks", 32'(n), 32'(DIV));
        drain();

        // Reset during 4th data bit of 0x0F: frame abandoned.
        send(0, 8'h0F, 0, 0);
        n = 0;
        while (txd[0] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4 * DIV + 3) @(negedge clk);
        chk("abort_busy_before_reset", 32'(busy[0]), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("abort_txd", 32'(txd[0]), 32'd1);
        chk("abort_ready", 32'(tx_ready[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(tx_done[0]), 32'd0);
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b1;
        send(0, 8'h81, 1, 0);
        drain();

`ifdef UART_TX_PARITY_EN
        send(0, 8'h07, 1, 0);
        send(0, 8'h03, 1, 0);
        drain();
`endif

        // Random traffic on both instances.
        for (int k = 0; k < 14; k++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send(int'($urandom_range(0, 1)), 8'($urandom), 1, 0);
        end
        drain();

        chk("done_count_dut0", 32'(done0), 32'(pushed0));
        chk("done_count_dut1", 32'(done1), 32'(pushed1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
